// File: rtl/serial_out.sv
// serial_out: streams stored data points out of RAM one bit at a time, LSB first.
// Each data point is (feat+1)*WORD_BITS bits wide and lives at consecutive RAM
// addresses starting at 0. A transfer is started with `start`, each word is
// fetched, loaded into a shift register and presented over a valid/ready bit
// interface, and `done` is raised once the last bit of the last word has been
// accepted by the sink.
module serial_out #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 192,
    parameter int WORD_BITS  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_dp,
    input  logic [3:0]            feat,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ser,
    output logic                  ser_valid,
    input  logic                  ser_ready,
    output logic                  sof,
    output logic                  busy,
    output logic                  done
);

    // Largest feature index that still fits in one RAM word (11 for 192/16).
    localparam int MAX_FEAT = DATA_WIDTH / WORD_BITS - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    // Control state
    state_t                  state_q,    state_d;
    logic [ADDR_WIDTH-1:0]   num_dp_q,   num_dp_d;
    logic [7:0]              last_bit_q, last_bit_d;
    logic [ADDR_WIDTH-1:0]   word_idx_q, word_idx_d;
    logic [7:0]              bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q,    shift_d;

    // Registered outputs
    logic                    rd_en_q,     rd_en_d;
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic                    ser_q,       ser_d;
    logic                    ser_valid_q, ser_valid_d;
    logic                    sof_q,       sof_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;

    // Helpers
    logic [3:0]              feat_clamped;
    logic [7:0]              last_bit_calc;
    logic [ADDR_WIDTH-1:0]   idx_next;
    logic                    bit_accept;

    // Clamp the requested feature count to what a RAM word can hold and turn it
    // into the index of the final bit of a word, so SHIFT only needs a compare.
    always_comb begin
        feat_clamped = feat;
        if ({28'd0, feat} > 32'(MAX_FEAT)) begin
            feat_clamped = 4'(MAX_FEAT);
        end
        last_bit_calc = 8'(({28'd0, feat_clamped} + 32'd1) * 32'(WORD_BITS) - 32'd1);
    end

    // Next-state logic for the transfer sequencer, plus output values derived
    // from the state being entered so that every output comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        num_dp_d   = num_dp_q;
        last_bit_d = last_bit_q;
        word_idx_d = word_idx_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;

        idx_next   = word_idx_q + ADDR_WIDTH'(1);
        bit_accept = ser_valid_q && ser_ready;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    num_dp_d   = num_dp;
                    last_bit_d = last_bit_calc;
                    word_idx_d = '0;
                    if (num_dp == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                shift_d   = rd_data;
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                if (bit_accept) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == last_bit_q) begin
                        bit_cnt_d  = '0;
                        word_idx_d = idx_next;
                        if (idx_next < num_dp_q) begin
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d     = (state_d == S_FETCH);
        addr_d      = (state_d == S_FETCH) ? word_idx_d : addr_q;
        ser_valid_d = (state_d == S_SHIFT);
        ser_d       = ser_valid_d && shift_d[0];
        sof_d       = ser_valid_d && (bit_cnt_d == 8'd0);
        busy_d      = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_SHIFT);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers; reset abandons any partial word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            num_dp_q    <= '0;
            last_bit_q  <= '0;
            word_idx_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            ser_q       <= 1'b0;
            ser_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_dp_q    <= num_dp_d;
            last_bit_q  <= last_bit_d;
            word_idx_q  <= word_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            ser_q       <= ser_d;
            ser_valid_q <= ser_valid_d;
            sof_q       <= sof_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign addr      = addr_q;
    assign ser       = ser_q;
    assign ser_valid = ser_valid_q;
    assign sof       = sof_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
